// File: rtl/mips_pkg.sv
// mips_pkg: constants, fetch-state encoding and IF/ID record shared by the fetch stage.
// Revision 1.0
`default_nettype none

package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_if_id_reg.sv
// mips_if_id_reg: IF/ID pipeline register, priority flush > stall > load > bubble.
// Revision 1.0
`default_nettype none

module mips_if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  if_id_t if_id_q, if_id_d;

  always_comb begin
    if_id_d = IF_ID_BUBBLE;
    if (flush_i) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (load_i) begin
      if_id_d.instr    = instr_i;
      if_id_d.pc_plus4 = pc_plus4_i;
      if_id_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instr_o    = if_id_q.instr;
  assign pc_plus4_o = if_id_q.pc_plus4;
  assign valid_o    = if_id_q.valid;

endmodule

`default_nettype wire

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: PC, fetch FSM (RUN/WAIT/WAIT_KILL) and instruction-memory handshake.
// Revision 1.0
`default_nettype none

module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pcsrc_d,
  input  logic [31:0] pc_branch_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_q, redirect_d;
  logic         req_q;

  logic         rdy;
  logic         redir;
  logic         load;

  // A ready seen while the request is still low belongs to a fetch abandoned by reset.
  assign rdy   = req_q & imem_ready;
  assign redir = pcsrc_d & ~stall_f;
  assign load  = rdy & ~stall_f & (state_q != WAIT_KILL);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    if (req_q) begin
      case (state_q)
        RUN, WAIT: begin
          if (rdy) begin
            state_d = RUN;
            if (!stall_f) begin
              pc_d = pcsrc_d ? pc_branch_d : pc_incr(pc_q);
            end
          end else if (redir) begin
            redirect_d = pc_branch_d;
            state_d    = WAIT_KILL;
          end else begin
            state_d = WAIT;
          end
        end
        WAIT_KILL: begin
          // The newest taken redirect wins, even one arriving with the killed word.
          if (redir) begin
            redirect_d = pc_branch_d;
          end
          if (rdy) begin
            pc_d    = redirect_d;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 32'h0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      req_q      <= 1'b1;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign fetch_busy = req_q & ~imem_ready;

  mips_if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (flush_d),
    .stall_i    (stall_d),
    .load_i     (load),
    .instr_i    (imem_rdata),
    .pc_plus4_i (pc_incr(pc_q)),
    .instr_o    (instr_d),
    .pc_plus4_o (pc_plus4_d),
    .valid_o    (valid_d)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: directed and random stimulus against a behavioural fetch model.
// Revision 1.0
`default_nettype none

module tb_mips_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pcsrc_d = 1'b0;
  logic [31:0] pc_branch_d = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, fetch_busy, valid_d;
  logic [31:0] imem_addr, instr_d, pc_plus4_d;

  int n_cmp = 0;
  int n_err = 0;

  // Model: PC, whether the outstanding fetch is doomed, pending target, IF/ID contents.
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  logic        m_req, m_kill, m_valid;

  always #5 clk = ~clk;

  mips_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pcsrc_d(pcsrc_d), .pc_branch_d(pc_branch_d), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_d(instr_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_busy(fetch_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_tgt = 32'h0; m_req = 1'b0; m_kill = 1'b0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic rdy, redir;
    rdy   = m_req && imem_ready;
    redir = pcsrc_d && !stall_f;
    if (flush_d) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (stall_d) begin
      // decode register keeps its contents
    end else if (rdy && !stall_f && !m_kill) begin
      m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end else begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end
    if (!m_req) begin
      m_req = 1'b1;
    end else if (m_kill) begin
      if (redir) m_tgt = pc_branch_d;
      if (rdy) begin
        m_pc = m_tgt; m_kill = 1'b0;
      end
    end else if (rdy) begin
      if (!stall_f) m_pc = pcsrc_d ? pc_branch_d : m_pc + 32'd4;
    end else if (redir) begin
      m_kill = 1'b1; m_tgt = pc_branch_d;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req), 32'(m_req));
    check({tag, "_addr"},  imem_addr, m_pc);
    check({tag, "_instr"}, instr_d, m_instr);
    check({tag, "_pc4"},   pc_plus4_d, m_pc4);
    check({tag, "_valid"}, 32'(valid_d), 32'(m_valid));
  endtask

  task automatic step(input logic sf, input logic sd, input logic fd, input logic pcs,
                      input logic [31:0] br, input logic rdy);
    stall_f = sf; stall_d = sd; flush_d = fd; pcsrc_d = pcs; pc_branch_d = br;
    imem_ready = rdy;
    imem_rdata = (imem_addr >> 2) + 32'd1;
    #1;
    check("busy", 32'(fetch_busy), 32'(m_req & rdy ? 1'b0 : m_req));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("step");
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst_busy", 32'(fetch_busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch from reset: ROM word i holds i+1.
    repeat (4) step(0, 0, 0, 0, 32'h0, 1);
    check("seq_instr", instr_d, 32'd3);
    check("seq_addr", imem_addr, 32'd12);

    // Taken branch together with a decode flush.
    step(0, 0, 1, 1, 32'h40, 1);
    check("flush_valid", 32'(valid_d), 32'h0);
    check("flush_addr", imem_addr, 32'h40);

    // Three-cycle memory wait at address 8.
    step(0, 0, 0, 1, 32'h8, 1);
    repeat (3) step(0, 0, 0, 0, 32'h0, 0);
    check("wait_addr", imem_addr, 32'h8);
    check("wait_valid", 32'(valid_d), 32'h0);
    step(0, 0, 0, 0, 32'h0, 1);
    check("wait_instr", instr_d, 32'd3);
    check("wait_pc4", pc_plus4_d, 32'd12);

    // Redirect arriving during a wait kills the outstanding word.
    step(0, 0, 0, 1, 32'h8, 1);
    step(0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 1, 32'h80, 0);
    step(0, 0, 0, 0, 32'h0, 1);
    check("kill_valid", 32'(valid_d), 32'h0);
    check("kill_addr", imem_addr, 32'h80);

    // Full stall ignores a redirect.
    step(0, 0, 0, 0, 32'h0, 1);
    repeat (2) step(1, 1, 0, 1, 32'h200, 1);
    check("stall_addr", imem_addr, 32'h84);
    check("stall_instr", instr_d, 32'h21);

    // PC wraps from the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0, 32'h0, 1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4", pc_plus4_d, 32'h0);
    check("wrap_instr", instr_d, 32'h4000_0000);

    // Reset in the middle of a wait; a late ready must be ignored.
    step(0, 0, 0, 0, 32'h0, 0);
    async_reset();
    step(0, 0, 0, 0, 32'h0, 1);
    check("late_valid", 32'(valid_d), 32'h0);
    step(0, 0, 0, 0, 32'h0, 1);
    check("restart_instr", instr_d, 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFFC;
      step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25,
           tgt, $urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_fetch_stage.md
MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  pipeline clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-004 SHALL have port stall_f  input  1  hazard-unit request to hold the PC.
REQ-005 SHALL have port stall_d  input  1  hazard-unit request to hold the IF/ID register.
REQ-006 SHALL have port flush_d  input  1  hazard-unit request to clear the IF/ID register.
REQ-007 SHALL have port pcsrc_d  input  1  branch/jump taken in decode.
REQ-008 SHALL have port pc_branch_d  input  32  redirect target.
REQ-009 SHALL have port imem_req  output  1  fetch request valid.
REQ-010 SHALL have port imem_addr  output  32  fetch address, equal to pc_f.
REQ-011 SHALL have port imem_ready  input  1  imem_rdata is valid for imem_addr this cycle.
REQ-012 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-013 SHALL have port instr_d  output  32  IF/ID instruction.
REQ-014 SHALL have port pc_plus4_d  output  32  IF/ID PC+4.
REQ-015 SHALL have port valid_d  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port fetch_busy  output  1  outstanding fetch not complete; hazard unit ORs this into its stalls.

Function
REQ-017 SHALL implement states RUN, WAIT, WAIT_KILL.
REQ-018 SHALL hold imem_req low for exactly the first rising edge after reset deassertion, then high continuously.
REQ-019 SHALL drive fetch_busy = imem_req and not imem_ready.
REQ-020 SHALL, in RUN with imem_ready=1 and stall_f=0, load pc_f with pc_branch_d if pcsrc_d=1, else pc_f+4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-021 SHALL, in RUN with imem_ready=0, hold pc_f and go to WAIT; if pcsrc_d=1 and stall_f=0, latch pc_branch_d into redirect_pc and go to WAIT_KILL instead.
REQ-022 SHALL, in WAIT, behave as RUN on imem_ready=1 (return to RUN); on imem_ready=0 with pcsrc_d=1 and stall_f=0, latch target and go to WAIT_KILL.
REQ-023 SHALL, in WAIT_KILL, overwrite redirect_pc on each new pcsrc_d=1 with stall_f=0; on imem_ready=1 discard imem_rdata, load pc_f from redirect_pc, return to RUN.
REQ-024 SHALL ignore pcsrc_d while stall_f=1 (stall has priority).
REQ-025 SHALL update IF/ID with priority flush_d > stall_d > load > bubble.
REQ-026 flush_d=1: instr_d=32'h0 (NOP), pc_plus4_d=0, valid_d=0 next edge.
REQ-027 stall_d=1 (flush_d=0): IF/ID holds all values.
REQ-028 load when imem_ready=1, stall_f=0, state not WAIT_KILL: instr_d=imem_rdata, pc_plus4_d=pc_f+4, valid_d=1.
REQ-029 otherwise SHALL insert a bubble (instr_d=0, pc_plus4_d=0, valid_d=0).
REQ-030 SHALL have fetch latency of one cycle: instruction accepted on edge N appears on instr_d after edge N.

Reset
REQ-031 SHALL asynchronously set pc_f=RESET_PC, state=RUN, redirect_pc=0, imem_req=0, instr_d=0, pc_plus4_d=0, valid_d=0 while reset=0.
REQ-032 SHALL, on reset mid-WAIT/WAIT_KILL, abandon the outstanding fetch; a late imem_ready after release SHALL only be honoured once imem_req=1.

Structure
REQ-033 SHALL place NOP encoding (32'h0), the fetch-state encoding and PC increment constant (4) in shared package mips_pkg.
REQ-034 SHALL instantiate the IF/ID register as sub-module mips_if_id_reg (flush/stall/load/bubble); FSM and PC stay in the top.

Verification
REQ-035 Reset release, imem_ready=1 always, ROM word i = i+1 -> imem_addr 0,4,8,...; instr_d 1,2,3 on successive cycles; valid_d=1 from second edge.
REQ-036 pcsrc_d=1 with pc_branch_d=32'h40, flush_d=1 same cycle -> next instr_d=0/valid_d=0, then imem_addr=32'h40.
REQ-037 imem_ready low 3 cycles at addr 8 -> fetch_busy=1 three cycles, pc_f holds 8, three bubbles, then word at 8 loads.
REQ-038 imem_ready low at addr 8, pcsrc_d=1 target 32'h80 during wait -> WAIT_KILL; word at 8 discarded (valid_d=0), next imem_addr=32'h80.
REQ-039 stall_f=stall_d=1 for 2 cycles with pcsrc_d=1 -> pc_f and IF/ID unchanged, redirect ignored.
REQ-040 reset pulled low mid-WAIT -> all outputs zero immediately, pc_f=RESET_PC, restart per REQ-035.
